// File: rtl/pkt_write_arbiter.sv
// Packet-level N:1 write arbiter: strict-priority or weighted round-robin grant,
// locked per packet, forwarded through a registered output stage with backpressure.
module pkt_write_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 64,
  parameter int PRI_W     = 3,
  parameter int DES_W     = 4,
  parameter int WEIGHT_W  = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sp0_wrr1,
  input  logic [(2**PRI_W)*WEIGHT_W-1:0]  weight_cfg,
  input  logic [NUM_PORTS-1:0]            in_vld,
  input  logic [NUM_PORTS-1:0]            in_sop,
  input  logic [NUM_PORTS-1:0]            in_eop,
  input  logic [NUM_PORTS*DATA_W-1:0]     in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_vld,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [DATA_W-1:0]               out_data,
  output logic [PORT_W-1:0]               out_port,
  output logic [DES_W-1:0]                out_des_port,
  output logic [PRI_W-1:0]                out_priority,
  input  logic                            out_ready,
  output logic                            busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state_q, state_d;
  logic [PORT_W-1:0]   grant_q, grant_d;
  logic [PORT_W-1:0]   last_q, last_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [PRI_W-1:0]    pri_q, pri_d;
  logic [DES_W-1:0]    des_q, des_d;
  logic                out_vld_q, out_vld_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [PORT_W-1:0]   out_port_q, out_port_d;
  logic [DES_W-1:0]    out_des_q, out_des_d;
  logic [PRI_W-1:0]    out_pri_q, out_pri_d;

  logic [DATA_W-1:0]   data_arr [NUM_PORTS];
  logic [PRI_W-1:0]    pri_arr  [NUM_PORTS];
  logic [DES_W-1:0]    des_arr  [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand;

  logic                win_found;
  logic [PORT_W-1:0]   win_port;
  logic [WEIGHT_W-1:0] win_credit;
  logic [PRI_W-1:0]    best_pri;
  logic [WEIGHT_W-1:0] wt_sel;
  int                  scan_idx;
  logic                grant_rdy;
  logic                accept;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
      assign pri_arr[gi]  = data_arr[gi][DES_W+PRI_W-1:DES_W];
      assign des_arr[gi]  = data_arr[gi][DES_W-1:0];
    end
  endgenerate

  assign cand      = in_vld & in_sop;
  assign grant_rdy = !out_vld_q || out_ready;
  assign accept    = (state_q == XFER) && in_vld[grant_q] && grant_rdy;

  // Winner selection; only consumed while IDLE, so mode/weights are sampled at grant time.
  always_comb begin
    win_found  = 1'b0;
    win_port   = '0;
    win_credit = '0;
    best_pri   = '0;
    wt_sel     = '0;
    scan_idx   = 0;
    if (!sp0_wrr1) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cand[i] && (!win_found || pri_arr[i] > best_pri)) begin
          win_found = 1'b1;
          win_port  = PORT_W'(i);
          best_pri  = pri_arr[i];
        end
      end
    end else if (credit_q != '0 && cand[last_q]) begin
      win_found  = 1'b1;
      win_port   = last_q;
      win_credit = credit_q - WEIGHT_W'(1);
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        scan_idx = (int'(last_q) + k) % NUM_PORTS;
        if (!win_found && cand[scan_idx]) begin
          win_found = 1'b1;
          win_port  = PORT_W'(scan_idx);
        end
      end
      wt_sel     = weight_cfg[pri_arr[win_port]*WEIGHT_W +: WEIGHT_W];
      win_credit = (wt_sel == '0) ? '0 : wt_sel - WEIGHT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = XFER;
      XFER:    if (accept && in_eop[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    last_d     = last_q;
    credit_d   = credit_q;
    pri_d      = pri_q;
    des_d      = des_q;
    out_vld_d  = out_vld_q && !out_ready;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_data_d = out_data_q;
    out_port_d = out_port_q;
    out_des_d  = out_des_q;
    out_pri_d  = out_pri_q;
    if (state_q == IDLE && win_found) begin
      grant_d  = win_port;
      last_d   = win_port;
      credit_d = win_credit;
      pri_d    = pri_arr[win_port];
      des_d    = des_arr[win_port];
    end
    // A new beat may load in the same cycle the previous one drains.
    if (accept) begin
      out_vld_d  = 1'b1;
      out_sop_d  = in_sop[grant_q];
      out_eop_d  = in_eop[grant_q];
      out_data_d = data_arr[grant_q];
      out_port_d = grant_q;
      out_des_d  = des_q;
      out_pri_d  = pri_q;
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst && state_q == XFER) in_ready[grant_q] = grant_rdy;
    busy = rst && (state_q != IDLE || out_vld_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= PORT_W'(NUM_PORTS-1);
      credit_q   <= '0;
      pri_q      <= '0;
      des_q      <= '0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_data_q <= '0;
      out_port_q <= '0;
      out_des_q  <= '0;
      out_pri_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      credit_q   <= credit_d;
      pri_q      <= pri_d;
      des_q      <= des_d;
      out_vld_q  <= out_vld_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_data_q <= out_data_d;
      out_port_q <= out_port_d;
      out_des_q  <= out_des_d;
      out_pri_q  <= out_pri_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;
  assign out_data     = out_data_q;
  assign out_port     = out_port_q;
  assign out_des_port = out_des_q;
  assign out_priority = out_pri_q;

endmodule

// File: tb/tb_pkt_write_arbiter.sv
// Directed bench for pkt_write_arbiter: a 16-port instance driven from per-port beat
// queues with an output log, plus a 5-port instance for circular-scan wrap-around.
module tb_pkt_write_arbiter;
  localparam int NP = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, sp0_wrr1, out_ready;
  logic [31:0]    weight_cfg;
  logic [NP-1:0]  in_vld, in_sop, in_eop, in_ready;
  logic [NP*DW-1:0] in_data;
  logic           out_vld, out_sop, out_eop, busy;
  logic [DW-1:0]  out_data;
  logic [3:0]     out_port, out_des_port;
  logic [2:0]     out_priority;

  logic [4:0]     in_vld5, in_sop5, in_eop5, in_ready5;
  logic [5*DW-1:0] in_data5;
  logic           out_vld5, out_sop5, out_eop5, busy5, out_ready5;
  logic [DW-1:0]  out_data5;
  logic [2:0]     out_port5;
  logic [3:0]     out_des5;
  logic [2:0]     out_pri5;

  pkt_write_arbiter dut (
    .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .weight_cfg(weight_cfg),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_ready(in_ready), .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .out_port(out_port), .out_des_port(out_des_port),
    .out_priority(out_priority), .out_ready(out_ready), .busy(busy)
  );

  pkt_write_arbiter #(.NUM_PORTS(5)) dut5 (
    .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .weight_cfg(weight_cfg),
    .in_vld(in_vld5), .in_sop(in_sop5), .in_eop(in_eop5), .in_data(in_data5),
    .in_ready(in_ready5), .out_vld(out_vld5), .out_sop(out_sop5), .out_eop(out_eop5),
    .out_data(out_data5), .out_port(out_port5), .out_des_port(out_des5),
    .out_priority(out_pri5), .out_ready(out_ready5), .busy(busy5)
  );

  typedef struct { logic gap; logic sop; logic eop; logic [63:0] data; } beat_t;
  typedef struct {
    logic [3:0] port; logic [63:0] data; logic sop; logic eop;
    logic [2:0] pri; logic [3:0] des; int cyc;
  } obeat_t;
  typedef struct {
    logic mode; int np; int p0; int r0; int p1; int r1; int p2; int r2;
    int exp_port; int exp_pri;
  } vec_t;

  beat_t  pq [NP][$];
  obeat_t log_q[$];
  obeat_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  logic   bp_chk = 1'b0;
  logic   rdy_toggle = 1'b0;

  function automatic logic [63:0] mkdata(int tag, int k, int pri, int des);
    return {16'(tag), 8'(k), 32'h0, 1'b0, 3'(pri), 4'(des)};
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, need %0h", name, got, exp);
    end
  endtask

  task automatic load_pkt(int port, int pri, int des, int len, int tag,
                          int gap_at = -1, int gap_n = 0, int sop_at = -1);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_n; g++) begin
          b.gap = 1'b1; b.sop = 1'b0; b.eop = 1'b0; b.data = '0;
          pq[port].push_back(b);
        end
      end
      b.gap = 1'b0;
      b.sop = (k == 0) || (k == sop_at);
      b.eop = (k == len - 1);
      b.data = mkdata(tag, k, pri, des);
      pq[port].push_back(b);
    end
  endtask

  task automatic exp_pkt(int port, int pri, int des, int len, int tag, int sop_at = -1);
    obeat_t e;
    for (int k = 0; k < len; k++) begin
      e.port = 4'(port); e.data = mkdata(tag, k, pri, des);
      e.sop = (k == 0) || (k == sop_at); e.eop = (k == len - 1);
      e.pri = 3'(pri); e.des = 4'(des); e.cyc = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (pq[i].size() != 0 && !pq[i][0].gap) begin
        in_vld[i] = 1'b1; in_sop[i] = pq[i][0].sop; in_eop[i] = pq[i][0].eop;
        in_data[i*DW +: DW] = pq[i][0].data;
      end else begin
        in_vld[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
        in_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // One clock: sample handshakes at negedge, then advance queues after the edge.
  task automatic step();
    logic [NP-1:0] acc;
    logic oacc;
    obeat_t ob;
    @(negedge clk);
    acc  = in_vld & in_ready;
    oacc = out_vld & out_ready;
    ob.port = out_port; ob.data = out_data; ob.sop = out_sop; ob.eop = out_eop;
    ob.pri = out_priority; ob.des = out_des_port; ob.cyc = cyc;
    if (bp_chk && out_vld && !out_ready) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    if (oacc) log_q.push_back(ob);
    for (int i = 0; i < NP; i++)
      if (pq[i].size() != 0 && (pq[i][0].gap || acc[i])) void'(pq[i].pop_front());
    if (rdy_toggle) out_ready = ~out_ready;
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NP; i++) pq[i].delete();
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy_toggle = 1'b0; bp_chk = 1'b0; out_ready = 1'b1;
    in_vld5 = '0; in_sop5 = '0; in_eop5 = '0; in_data5 = '0;
    clear_all();
    drive();
    step(); step();
    rst = 1'b1;
    log_q.delete();
  endtask

  task automatic run_until(int n, int budget, string name);
    int c = 0;
    while (log_q.size() < n && c < budget) begin step(); c++; end
    n_cmp++;
    if (log_q.size() < n) begin
      n_err++;
      $display("FAIL %s timeout: got %0d beats, need %0d", name, log_q.size(), n);
    end
  endtask

  task automatic check_log(string name);
    n_cmp++;
    if (log_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s beat count: got %0d, need %0d", name, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].port !== exp_q[i].port || log_q[i].data !== exp_q[i].data ||
          log_q[i].sop !== exp_q[i].sop || log_q[i].eop !== exp_q[i].eop ||
          log_q[i].pri !== exp_q[i].pri || log_q[i].des !== exp_q[i].des) begin
        n_err++;
        $display("FAIL %s beat %0d: got port=%0d data=%h sop=%b eop=%b pri=%0d des=%0d, need port=%0d data=%h sop=%b eop=%b pri=%0d des=%0d",
                 name, i, log_q[i].port, log_q[i].data, log_q[i].sop, log_q[i].eop,
                 log_q[i].pri, log_q[i].des, exp_q[i].port, exp_q[i].data,
                 exp_q[i].sop, exp_q[i].eop, exp_q[i].pri, exp_q[i].des);
      end
    end
  endtask

  function automatic int lcyc(int i);
    return (i < log_q.size()) ? log_q[i].cyc : -1000;
  endfunction

  function automatic int lport(int i);
    return (i < log_q.size()) ? int'(log_q[i].port) : -1;
  endfunction

  initial begin
    vec_t vt[9];
    int   start, n_seen;
    int   wrr_exp[8];
    int   w0_exp[4];

    vt[0] = '{mode:0, np:1, p0:3,  r0:2, p1:0,  r1:0, p2:0,  r2:0, exp_port:3,  exp_pri:2};
    vt[1] = '{mode:0, np:2, p0:0,  r0:1, p1:15, r1:6, p2:0,  r2:0, exp_port:15, exp_pri:6};
    vt[2] = '{mode:0, np:3, p0:4,  r0:7, p1:5,  r1:7, p2:6,  r2:7, exp_port:4,  exp_pri:7};
    vt[3] = '{mode:0, np:2, p0:14, r0:0, p1:1,  r1:0, p2:0,  r2:0, exp_port:1,  exp_pri:0};
    vt[4] = '{mode:0, np:3, p0:12, r0:3, p1:8,  r1:6, p2:10, r2:6, exp_port:8,  exp_pri:6};
    vt[5] = '{mode:1, np:2, p0:9,  r0:0, p1:5,  r1:7, p2:0,  r2:0, exp_port:5,  exp_pri:7};
    vt[6] = '{mode:1, np:1, p0:15, r0:4, p1:0,  r1:0, p2:0,  r2:0, exp_port:15, exp_pri:4};
    vt[7] = '{mode:1, np:2, p0:15, r0:1, p1:0,  r1:2, p2:0,  r2:0, exp_port:0,  exp_pri:2};
    vt[8] = '{mode:1, np:2, p0:14, r0:6, p1:15, r1:3, p2:0,  r2:0, exp_port:14, exp_pri:6};
    wrr_exp = '{0, 0, 0, 1, 0, 0, 0, 1};
    w0_exp  = '{2, 3, 2, 3};

    // Reset held with every input active
    rst = 1'b0; out_ready = 1'b1; out_ready5 = 1'b1;
    sp0_wrr1 = 1'b1; weight_cfg = '1;
    in_vld = '1; in_sop = '1; in_eop = '1; in_data = '1;
    in_vld5 = '1; in_sop5 = '1; in_eop5 = '1; in_data5 = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_qualifiers", 64'({out_vld, out_sop, out_eop}), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_tags", 64'({out_port, out_des_port, out_priority}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dut5", 64'({in_ready5, out_vld5, busy5}), 64'd0);

    // Reset asserted mid-packet
    do_reset();
    sp0_wrr1 = 1'b0;
    load_pkt(3, 1, 9, 8, 'h30);
    drive();
    run_until(3, 50, "rstmid_start");
    rst = 1'b0;
    step();
    chk("rstmid_out_vld", 64'(out_vld), 64'd0);
    clear_all();
    drive();
    step();
    rst = 1'b1;
    n_seen = 0;
    repeat (10) begin step(); if (out_vld) n_seen++; end
    chk("rstmid_no_out", 64'(n_seen), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);

    // Single-beat arbitration vectors, each from a fresh reset
    for (int v = 0; v < 9; v++) begin
      do_reset();
      sp0_wrr1 = vt[v].mode;
      weight_cfg = 32'h0000_0130;
      load_pkt(vt[v].p0, vt[v].r0, vt[v].p0, 1, 100 + v);
      if (vt[v].np > 1) load_pkt(vt[v].p1, vt[v].r1, vt[v].p1, 1, 100 + v);
      if (vt[v].np > 2) load_pkt(vt[v].p2, vt[v].r2, vt[v].p2, 1, 100 + v);
      drive();
      start = cyc;
      run_until(vt[v].np, 100, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_port", v), 64'(lport(0)), 64'(vt[v].exp_port));
      if (log_q.size() > 0) begin
        chk($sformatf("vec%0d_pri", v), 64'(log_q[0].pri), 64'(vt[v].exp_pri));
        chk($sformatf("vec%0d_des", v), 64'(log_q[0].des), 64'(vt[v].exp_port));
      end
      chk($sformatf("vec%0d_latency", v), 64'(lcyc(0) - start), 64'd2);
    end

    // Strict priority: 2 and 7 tie at pri 5, then 9 at pri 3
    do_reset();
    sp0_wrr1 = 1'b0;
    load_pkt(2, 5, 1, 4, 'h20); load_pkt(7, 5, 2, 4, 'h70); load_pkt(9, 3, 3, 4, 'h90);
    drive();
    exp_pkt(2, 5, 1, 4, 'h20); exp_pkt(7, 5, 2, 4, 'h70); exp_pkt(9, 3, 3, 4, 'h90);
    run_until(12, 200, "sp");
    repeat (4) step();
    check_log("sp");
    chk("sp_pkt_period1", 64'(lcyc(4) - lcyc(0)), 64'd5);
    chk("sp_pkt_period2", 64'(lcyc(8) - lcyc(4)), 64'd5);

    // WRR with pri1 weight 3, pri2 weight 1
    do_reset();
    sp0_wrr1 = 1'b1;
    weight_cfg = 32'h0000_0130;
    for (int k = 0; k < 10; k++) begin
      load_pkt(0, 1, 0, 1, 'h200 + k);
      load_pkt(1, 2, 1, 1, 'h300 + k);
    end
    drive();
    run_until(8, 200, "wrr");
    for (int i = 0; i < 8; i++) chk($sformatf("wrr_grant%0d", i), 64'(lport(i)), 64'(wrr_exp[i]));

    // Weight 0 acts as 1: two pri-0 ports alternate
    do_reset();
    sp0_wrr1 = 1'b1;
    weight_cfg = 32'h0000_0130;
    for (int k = 0; k < 4; k++) begin
      load_pkt(2, 0, 2, 1, 'h400 + k);
      load_pkt(3, 0, 3, 1, 'h500 + k);
    end
    drive();
    run_until(4, 100, "wrr_w0");
    for (int i = 0; i < 4; i++) chk($sformatf("wrr_w0_grant%0d", i), 64'(lport(i)), 64'(w0_exp[i]));

    // Backpressure with out_ready toggling
    do_reset();
    sp0_wrr1 = 1'b0;
    load_pkt(6, 4, 5, 8, 'h600);
    drive();
    exp_pkt(6, 4, 5, 8, 'h600);
    rdy_toggle = 1'b1;
    bp_chk = 1'b1;
    run_until(8, 200, "bp");
    repeat (4) step();
    rdy_toggle = 1'b0;
    bp_chk = 1'b0;
    out_ready = 1'b1;
    check_log("bp");

    // Mid-packet valid gap with a competing sop, plus a stray sop on a body beat
    do_reset();
    sp0_wrr1 = 1'b0;
    load_pkt(5, 6, 7, 6, 'h500, 3, 3, 3);
    load_pkt(4, 2, 8, 2, 'h400);
    drive();
    exp_pkt(5, 6, 7, 6, 'h500, 3);
    exp_pkt(4, 2, 8, 2, 'h400);
    run_until(8, 200, "gap");
    repeat (3) step();
    check_log("gap");
    chk("gap_stall_len", 64'(lcyc(3) - lcyc(2)), 64'd4);
    chk("gap_idle_cycle", 64'(lcyc(6) - lcyc(5)), 64'd2);

    // 5-port wrap-around: last = 4, candidates {1,3}
    do_reset();
    sp0_wrr1 = 1'b1;
    in_vld5 = 5'b01010; in_sop5 = 5'b01010; in_eop5 = 5'b01010; in_data5 = '0;
    @(posedge clk); #1;
    chk("wrap_ready_t1", 64'(in_ready5), 64'h02);
    chk("wrap_busy_t1", 64'(busy5), 64'd1);
    @(posedge clk); #1;
    in_vld5[1] = 1'b0; in_sop5[1] = 1'b0; in_eop5[1] = 1'b0;
    chk("wrap_out_t2", 64'({out_vld5, out_sop5, out_eop5, out_port5}), 64'({3'b111, 3'd1}));
    chk("wrap_idle_t2", 64'(in_ready5), 64'd0);
    @(posedge clk); #1;
    chk("wrap_ready_t3", 64'(in_ready5), 64'h08);
    chk("wrap_drained_t3", 64'(out_vld5), 64'd0);
    @(posedge clk); #1;
    in_vld5 = '0; in_sop5 = '0; in_eop5 = '0;
    chk("wrap_out_t4", 64'({out_vld5, out_port5}), 64'({1'b1, 3'd3}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
